// File: rtl/rect_polar_cordic_if.sv
// Sample/result handshake bundle for the rectangular-to-polar CORDIC.
// The block being fed uses the slave modport; whatever drives it uses master.
interface rect_polar_cordic_if #(
  parameter int W       = 8,
  parameter int ANGLE_W = 8
);
  logic signed [W-1:0] in_x;
  logic signed [W-1:0] in_y;
  logic                in_valid;
  logic                in_ready;
  logic [W-1:0]        out_mag;
  logic [ANGLE_W-1:0]  out_angle;
  logic                out_zero;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output in_x, in_y, in_valid, out_ready,
    input  in_ready, out_mag, out_angle, out_zero, out_valid
  );

  modport slave (
    input  in_x, in_y, in_valid, out_ready,
    output in_ready, out_mag, out_angle, out_zero, out_valid
  );
endinterface

// File: rtl/rect_polar_cordic.sv
// Iterative vectoring-mode CORDIC: signed (x, y) in, magnitude and full-circle angle out.
// States: IDLE wait for sample | ROT one micro-rotation per cycle | SCALE gain fix | DONE hold result.
module rect_polar_cordic #(
  parameter int W       = 8,
  parameter int ANGLE_W = 8,
  parameter int ITER    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  rect_polar_cordic_if.slave bus
);
  localparam int XW = W + 2;
  localparam int ZW = ANGLE_W + 2;
  localparam logic [3:0] LAST = 4'(ITER - 1);
  localparam logic signed [ZW-1:0] HALF = {2'b10, {ANGLE_W{1'b0}}};

  typedef enum logic [1:0] {IDLE, ROT, SCALE, DONE} state_t;

  state_t               state_q, state_d;
  logic signed [XW-1:0] x_q, x_d, y_q, y_d;
  logic signed [ZW-1:0] z_q, z_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 zflag_q, zflag_d;
  logic [W-1:0]         mag_q, mag_d;
  logic [ANGLE_W-1:0]   ang_q, ang_d;
  logic                 ozero_q, ozero_d;
  logic                 oval_q, oval_d;

  logic signed [XW-1:0] x_in, y_in, x_sh, y_sh, m;
  logic signed [ZW-1:0] z_rnd, atan_i;

  // atan(2^-i) as a fraction of a full circle, 32-bit, rounded to ZW bits.
  function automatic logic [ZW-1:0] atan_lut(input logic [3:0] idx);
    logic [31:0] ent;
    logic [32:0] rnd;
    case (idx)
      4'd0:    ent = 32'h2000_0000;
      4'd1:    ent = 32'h12E4_051E;
      4'd2:    ent = 32'h09FB_385B;
      4'd3:    ent = 32'h0511_11D4;
      4'd4:    ent = 32'h028B_0D43;
      4'd5:    ent = 32'h0145_D7E1;
      4'd6:    ent = 32'h00A2_F61E;
      4'd7:    ent = 32'h0051_7C55;
      4'd8:    ent = 32'h0028_BE53;
      4'd9:    ent = 32'h0014_5F2F;
      4'd10:   ent = 32'h000A_2F98;
      4'd11:   ent = 32'h0005_17CC;
      4'd12:   ent = 32'h0002_8BE6;
      4'd13:   ent = 32'h0001_45F3;
      4'd14:   ent = 32'h0000_A2FA;
      default: ent = 32'h0000_517D;
    endcase
    rnd = {1'b0, ent} + (33'd1 << (31 - ZW));
    return ZW'(rnd >> (32 - ZW));
  endfunction

  assign x_in   = XW'(bus.in_x);
  assign y_in   = XW'(bus.in_y);
  assign x_sh   = x_q >>> cnt_q;
  assign y_sh   = y_q >>> cnt_q;
  assign atan_i = atan_lut(cnt_q);
  // 1/K ~= 0.607422 as shift-add
  assign m      = (x_q >>> 1) + (x_q >>> 3) - (x_q >>> 6) - (x_q >>> 9);
  assign z_rnd  = z_q + ZW'(2);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    cnt_d   = cnt_q;
    zflag_d = zflag_q;
    mag_d   = mag_q;
    ang_d   = ang_q;
    ozero_d = ozero_q;
    oval_d  = oval_q;
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            if (bus.in_x[W-1]) begin
              x_d = -x_in;
              y_d = -y_in;
              z_d = HALF;
            end else begin
              x_d = x_in;
              y_d = y_in;
              z_d = '0;
            end
            zflag_d = (bus.in_x == '0) && (bus.in_y == '0);
            cnt_d   = '0;
            state_d = ROT;
          end
        end
        ROT: begin
          if (!y_q[XW-1]) begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + atan_i;
          end else begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - atan_i;
          end
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == LAST) state_d = SCALE;
        end
        SCALE: begin
          mag_d   = zflag_q ? '0 : W'(m);
          ang_d   = zflag_q ? '0 : ANGLE_W'(z_rnd >>> 2);
          ozero_d = zflag_q;
          oval_d  = 1'b1;
          state_d = DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            oval_d  = 1'b0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      cnt_q   <= '0;
      zflag_q <= 1'b0;
      mag_q   <= '0;
      ang_q   <= '0;
      ozero_q <= 1'b0;
      oval_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      cnt_q   <= cnt_d;
      zflag_q <= zflag_d;
      mag_q   <= mag_d;
      ang_q   <= ang_d;
      ozero_q <= ozero_d;
      oval_q  <= oval_d;
    end
  end

  assign bus.in_ready  = ena && (state_q == IDLE);
  assign bus.out_mag   = mag_q;
  assign bus.out_angle = ang_q;
  assign bus.out_zero  = ozero_q;
  assign bus.out_valid = oval_q;
endmodule

// File: tb/tb_rect_polar_cordic.sv
// Bench for rect_polar_cordic: directed and random vectors against a real-arithmetic CORDIC model.
module tb_rect_polar_cordic;
  localparam int  W    = 8;
  localparam int  AW   = 8;
  localparam int  ITER = 8;
  localparam real PI   = 3.141592653589793;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ena   = 1'b0;
  int   checks = 0;
  int   errors = 0;

  rect_polar_cordic_if #(.W(W), .ANGLE_W(AW)) bus ();

  rect_polar_cordic #(.W(W), .ANGLE_W(AW), .ITER(ITER)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // floor(v / 2^s) in real arithmetic
  function automatic int fdiv(input int v, input int s);
    real d;
    d = 1.0;
    for (int k = 0; k < s; k++) d = d * 2.0;
    return int'($floor(real'(v) / d));
  endfunction

  function automatic int atan_units(input int i);
    real t;
    t = 1.0;
    for (int k = 0; k < i; k++) t = t / 2.0;
    return int'($floor($atan(t) / (2.0 * PI) * real'(1 << (AW + 2)) + 0.5));
  endfunction

  function automatic void model(input int xi, input int yi,
                                output int mag, output int ang, output int zf);
    int  x, y, z, xn;
    bit  up;
    zf = (xi == 0 && yi == 0) ? 1 : 0;
    if (xi < 0) begin
      x = -xi; y = -yi; z = 1 << (AW + 1);
    end else begin
      x = xi;  y = yi;  z = 0;
    end
    for (int i = 0; i < ITER; i++) begin
      up = (y >= 0);
      xn = up ? x + fdiv(y, i) : x - fdiv(y, i);
      y  = up ? y - fdiv(x, i) : y + fdiv(x, i);
      z  = up ? z + atan_units(i) : z - atan_units(i);
      x  = xn;
    end
    mag = (fdiv(x, 1) + fdiv(x, 3) - fdiv(x, 6) - fdiv(x, 9)) % (1 << W);
    ang = fdiv(z + 2, 2) % (1 << AW);
    if (ang < 0) ang += (1 << AW);
    if (zf != 0) begin
      mag = 0;
      ang = 0;
    end
  endfunction

  task automatic txn(input int xi, input int yi, input int stall_at,
                     input int stall_len, input int hold);
    int emag, eang, ez, lat, k;
    model(xi, yi, emag, eang, ez);
    @(negedge clk);
    bus.in_x     = W'(xi);
    bus.in_y     = W'(yi);
    bus.in_valid = 1'b1;
    k = 0;
    while (bus.in_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("accept", int'(bus.in_ready), 1);
    if (bus.in_ready !== 1'b1) begin
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 60) begin
      if (lat == stall_at) begin
        ena          = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_x     = W'(xi ^ 5);
      end
      if (lat == stall_at + stall_len) begin
        ena          = 1'b1;
        bus.in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
      if (ena == 1'b0) chk("stall_in_ready", int'(bus.in_ready), 0);
    end
    ena          = 1'b1;
    bus.in_valid = 1'b0;
    chk("latency", lat, ITER + 2 + ((stall_at > 0) ? stall_len : 0));
    chk("mag", int'(bus.out_mag), emag);
    chk("angle", int'(bus.out_angle), eang);
    chk("zero", int'(bus.out_zero), ez);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", int'(bus.out_valid), 1);
      chk("hold_in_ready", int'(bus.in_ready), 0);
      chk("hold_mag", int'(bus.out_mag), emag);
      chk("hold_angle", int'(bus.out_angle), eang);
    end
    bus.out_ready = 1'b1;
    if (hold >= 2) begin
      ena = 1'b0;
      @(posedge clk);
      #1;
      chk("ena_ignores_out_ready", int'(bus.out_valid), 1);
      ena = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("release_valid", int'(bus.out_valid), 0);
    chk("release_in_ready", int'(bus.in_ready), 1);
    chk("keep_mag", int'(bus.out_mag), emag);
    chk("keep_angle", int'(bus.out_angle), eang);
  endtask

  initial begin
    int rx, ry, sa;
    bus.in_x      = '0;
    bus.in_y      = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    ena           = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_mag", int'(bus.out_mag), 0);
    chk("rst_angle", int'(bus.out_angle), 0);
    chk("rst_zero", int'(bus.out_zero), 0);
    chk("rst_in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    txn(100, 0, -1, 0, 0);
    txn(0, 100, -1, 0, 0);
    txn(-100, 0, -1, 0, 0);
    txn(0, -100, -1, 0, 0);
    txn(-128, -128, -1, 0, 0);
    txn(127, 127, -1, 0, 0);
    txn(-128, 127, -1, 0, 1);
    txn(3, 4, -1, 0, 0);
    txn(0, 0, -1, 0, 0);
    txn(0, 100, -1, 0, 5);
    txn(-77, 45, 2, 3, 0);
    txn(-77, 45, -1, 0, 2);

    // asynchronous reset two cycles into the rotation
    @(negedge clk);
    bus.in_x     = W'(37);
    bus.in_y     = W'(-90);
    bus.in_valid = 1'b1;
    chk("mid_rst_accept", int'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", int'(bus.out_valid), 0);
    chk("mid_rst_mag", int'(bus.out_mag), 0);
    chk("mid_rst_angle", int'(bus.out_angle), 0);
    chk("mid_rst_zero", int'(bus.out_zero), 0);
    chk("mid_rst_in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(posedge clk);
      #1;
      chk("post_rst_idle", int'(bus.out_valid), 0);
    end
    txn(100, 0, -1, 0, 0);

    for (int n = 0; n < 30; n++) begin
      rx = int'($urandom_range(0, 255)) - 128;
      ry = int'($urandom_range(0, 255)) - 128;
      sa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 8)) : -1;
      txn(rx, ry, sa, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
